tow_match_ctrl: RTL and testbench

Best-of-N match sequencer for the tug-of-war game. It sits above the per-round datapath (scorer, master controller, speed logic) and runs on the divided game clock. It clears and enables each round, tallies round winners, and inserts a timed pause between rounds. When the match ends, it drives a winner pattern onto the LED override path.

---
 rtl/tow_match_pkg.sv | 17 +
 rtl/match_pause_timer.sv | 29 ++
 rtl/tow_match_ctrl.sv | 124 ++++++++++++
 tb/tb_tow_match_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/tow_match_pkg.sv
// Shared types and constants for the tug-of-war best-of-N match sequencer.
package tow_match_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } match_state_t;

    localparam int WIN_W = 3;

    localparam logic [6:0] LED_WIN_RIGHT = 7'b0000111;
    localparam logic [6:0] LED_WIN_LEFT  = 7'b1110000;

endpackage

// File: rtl/match_pause_timer.sv
// Loadable down-counter stepped by slowen; expired is a one-cycle pulse on the
// slowen that brings the count to zero, so the FSM can leave PAUSE on that edge.
module match_pause_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             slowen,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && slowen && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = en && slowen && (cnt == CNT_W'(1));

endmodule

// File: rtl/tow_match_ctrl.sv
// Best-of-N match sequencer: clears/enables rounds, tallies winners, pauses
// between rounds and drives the winner LED pattern. Optional: TOW_MATCH_BLINK_EN.
module tow_match_ctrl
    import tow_match_pkg::*;
#(
    parameter int ROUNDS_TO_WIN = 2,
    parameter int PAUSE_TICKS   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             slowen,
    input  logic             round_done,
    input  logic             round_right,
    output logic             round_clear,
    output logic             round_enable,
    output logic [WIN_W-1:0] wins_left,
    output logic [WIN_W-1:0] wins_right,
    output logic             match_over,
    output logic             match_right,
    output logic             led_ovr_en,
    output logic [6:0]       led_ovr
);

    localparam logic [WIN_W-1:0] WIN_TGT = WIN_W'(ROUNDS_TO_WIN);

    match_state_t     state, state_nxt;
    logic [WIN_W-1:0] wl_nxt, wr_nxt;
    logic             mr_nxt;
    logic             pause_load;
    logic             pause_expired;
    logic [6:0]       win_pat;
    logic [6:0]       led_nxt;

    match_pause_timer #(.CNT_W(8)) u_pause (
        .clk      (clk),
        .rst      (rst),
        .load     (pause_load),
        .load_val (8'(PAUSE_TICKS)),
        .en       (state == ST_PAUSE),
        .slowen   (slowen),
        .expired  (pause_expired)
    );

    always_comb begin
        state_nxt  = state;
        wl_nxt     = wins_left;
        wr_nxt     = wins_right;
        mr_nxt     = match_right;
        pause_load = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_CLEAR;
                    wl_nxt    = '0;
                    wr_nxt    = '0;
                    mr_nxt    = 1'b0;
                end
            end
            ST_CLEAR: state_nxt = ST_PLAY;
            ST_PLAY: begin
                // start is deliberately ignored here, even alongside round_done
                if (round_done) begin
                    if (round_right) begin
                        if (wins_right < WIN_TGT) wr_nxt = wins_right + 1'b1;
                    end else begin
                        if (wins_left < WIN_TGT) wl_nxt = wins_left + 1'b1;
                    end
                    if ((round_right ? wr_nxt : wl_nxt) == WIN_TGT) begin
                        state_nxt = ST_DONE;
                        mr_nxt    = round_right;
                    end else begin
                        state_nxt  = ST_PAUSE;
                        pause_load = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (pause_expired) state_nxt = ST_CLEAR;
            end
            default: state_nxt = ST_IDLE;
        endcase

        win_pat = mr_nxt ? LED_WIN_RIGHT : LED_WIN_LEFT;
        led_nxt = '0;
        if (state_nxt == ST_DONE) begin
            if (state != ST_DONE) begin
                led_nxt = win_pat;
            end else begin
`ifdef TOW_MATCH_BLINK_EN
                led_nxt = slowen ? ((led_ovr == '0) ? win_pat : 7'b0000000) : led_ovr;
`else
                led_nxt = win_pat;
`endif
            end
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            wins_left    <= '0;
            wins_right   <= '0;
            match_right  <= 1'b0;
            round_clear  <= 1'b0;
            round_enable <= 1'b0;
            match_over   <= 1'b0;
            led_ovr_en   <= 1'b0;
            led_ovr      <= '0;
        end else begin
            state        <= state_nxt;
            wins_left    <= wl_nxt;
            wins_right   <= wr_nxt;
            match_right  <= mr_nxt;
            round_clear  <= (state_nxt == ST_CLEAR);
            round_enable <= (state_nxt == ST_PLAY);
            match_over   <= (state_nxt == ST_DONE);
            led_ovr_en   <= (state_nxt == ST_DONE);
            led_ovr      <= led_nxt;
        end
    end

endmodule

// File: tb/tb_tow_match_ctrl.sv
// Directed bench for tow_match_ctrl (ROUNDS_TO_WIN=2, PAUSE_TICKS=4).
module tb_tow_match_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       slowen = 1'b0;
    logic       round_done = 1'b0;
    logic       round_right = 1'b0;
    logic       round_clear, round_enable, match_over, match_right, led_ovr_en;
    logic [2:0] wins_left, wins_right;
    logic [6:0] led_ovr;

    int n_chk = 0;
    int n_pass = 0;

    tow_match_ctrl #(.ROUNDS_TO_WIN(2), .PAUSE_TICKS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .slowen       (slowen),
        .round_done   (round_done),
        .round_right  (round_right),
        .round_clear  (round_clear),
        .round_enable (round_enable),
        .wins_left    (wins_left),
        .wins_right   (wins_right),
        .match_over   (match_over),
        .match_right  (match_right),
        .led_ovr_en   (led_ovr_en),
        .led_ovr      (led_ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All outputs packed: clear, enable, wl, wr, over, right, ovr_en, led
    function automatic logic [31:0] outs();
        return 32'({round_clear, round_enable, wins_left, wins_right,
                    match_over, match_right, led_ovr_en, led_ovr});
    endfunction

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic win(input logic right);
        round_done = 1'b1; round_right = right; step(); round_done = 1'b0;
    endtask

    // Four slowen ticks with idle gaps; round_clear only after the fourth.
    task automatic run_pause(input string tag);
        for (int i = 0; i < 4; i++) begin
            slowen = 1'b1; step(); slowen = 1'b0;
            if (i < 3) begin
                step();
                if (i == 1) chk({tag, "_midclr"}, round_clear, 1'b0);
            end
        end
        chk({tag, "_clr"}, round_clear, 1'b1);
        step();
        chk({tag, "_en"}, round_enable, 1'b1);
    endtask

    initial begin
        step(); step();
        chk("reset_outs", outs(), 32'h0);
        rst = 1'b0;
        step(); step(); step();
        chk("idle_outs", outs(), 32'h0);

        pulse_start();
        chk("start_clr", {round_clear, round_enable}, 2'b10);
        step();
        chk("start_en", {round_clear, round_enable}, 2'b01);

        win(1'b1);
        chk("r1_wins", {wins_left, wins_right}, 6'o01);
        chk("r1_en_drop", round_enable, 1'b0);
        win(1'b0);
        win(1'b1);
        chk("pause_rd_ignored", {wins_left, wins_right}, 6'o01);
        run_pause("p1");

        // Same-cycle round_done and start: only the win counts.
        start = 1'b1;
        win(1'b0);
        start = 1'b0;
        chk("r2_wins", {wins_left, wins_right}, 6'o11);
        chk("r2_no_restart", {round_clear, round_enable, match_over}, 3'b000);
        run_pause("p2");

        win(1'b1);
        chk("r3_wins", {wins_left, wins_right}, 6'o12);
        chk("done_flags", {match_over, match_right, led_ovr_en, round_enable}, 4'b1110);
        chk("done_led_r", led_ovr, 7'b0000111);
        slowen = 1'b1; step(); slowen = 1'b0;
`ifdef TOW_MATCH_BLINK_EN
        chk("done_r_tick", led_ovr, 7'b0000000);
`else
        chk("done_r_tick", led_ovr, 7'b0000111);
`endif

        // start together with slowen in DONE: restart wins
        start = 1'b1; slowen = 1'b1; step(); start = 1'b0; slowen = 1'b0;
        chk("restart_outs", outs(), 32'({1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 7'd0}));
        step();
        chk("restart_en", round_enable, 1'b1);

        // Reset mid-pause with two ticks remaining
        win(1'b1);
        slowen = 1'b1; step(); slowen = 1'b0; step();
        slowen = 1'b1; step(); slowen = 1'b0;
        chk("midpause_wins", {wins_left, wins_right, round_clear}, 7'b000_001_0);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_pause_outs", outs(), 32'h0);
        slowen = 1'b1; step(); slowen = 1'b0; step();
        slowen = 1'b1; step(); slowen = 1'b0;
        chk("rst_stays_idle", outs(), 32'h0);

        // Full new match won by the left player
        pulse_start();
        chk("m2_clr", round_clear, 1'b1);
        step();
        win(1'b0);
        chk("m2_r1", {wins_left, wins_right}, 6'o10);
        run_pause("p3");
        win(1'b0);
        chk("m2_wins", {wins_left, wins_right}, 6'o20);
        chk("m2_flags", {match_over, match_right, led_ovr_en}, 3'b101);
        chk("m2_led0", led_ovr, 7'b1110000);
        for (int i = 1; i <= 3; i++) begin
            step();
            slowen = 1'b1; step(); slowen = 1'b0;
`ifdef TOW_MATCH_BLINK_EN
            chk($sformatf("m2_led%0d", i), led_ovr, (i % 2 == 1) ? 7'b0000000 : 7'b1110000);
`else
            chk($sformatf("m2_led%0d", i), led_ovr, 7'b1110000);
`endif
            chk($sformatf("m2_ovr_en%0d", i), led_ovr_en, 1'b1);
        end
        win(1'b0);
        chk("done_rd_ignored", {wins_left, wins_right, match_over}, 7'b010_000_1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
